// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and default sizes for the async-FIFO read-side packer.
package fifo_pkg;

  localparam int DEF_DATA_LINES     = 8;
  localparam int DEF_PACK_RATIO     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef logic [DEF_DATA_LINES-1:0]  lane_t;
  typedef lane_t [DEF_PACK_RATIO-1:0] pack_word_t;
  typedef logic [DEF_PACK_RATIO-1:0]  keep_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Valid/ready word stream carrying packed lanes plus a lane-valid mask.
interface fifo_rd_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_LINES = DEF_DATA_LINES,
  parameter int PACK_RATIO = DEF_PACK_RATIO
);

  logic [DATA_LINES*PACK_RATIO-1:0] m_data;
  logic [PACK_RATIO-1:0]            m_keep;
  logic                             m_valid;
  logic                             m_ready;

  modport master (output m_data, output m_keep, output m_valid, input  m_ready);
  modport slave  (input  m_data, input  m_keep, input  m_valid, output m_ready);

endinterface

// File: rtl/fifo_rd_packer_idle_timer.sv
// Idle counter for the packer: requests a flush after TIMEOUT_CYCLES idle cycles.
module pack_idle_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic clear,
  output logic flush_req
);

  localparam int             TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt_q, cnt_d;

  // The count saturates at LIMIT so the request stays up until the flush lands.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = '0;
    else if (idle && cnt_q != LIMIT)  cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign flush_req = (cnt_q == LIMIT);

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO bytes popped from the async FIFO read port into one wide word.
// Define PACK_TIMEOUT_EN to flush partial words after TIMEOUT_CYCLES idle cycles.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_LINES     = DEF_DATA_LINES,
  parameter int PACK_RATIO     = DEF_PACK_RATIO,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_LINES-1:0] rdata,
  output logic                  rinc,
  fifo_rd_packer_if.master      m_if
);

  localparam int            CW   = $clog2(PACK_RATIO + 1);
  localparam int            IW   = $clog2(PACK_RATIO);
  localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);

  logic [PACK_RATIO-1:0][DATA_LINES-1:0] acc_q, acc_d;
  logic [CW-1:0]                         acc_count_q, acc_count_d, base_count;
  logic                                  rd_pend_q, rd_pend_d;
  logic [DATA_LINES*PACK_RATIO-1:0]      m_data_q, m_data_d;
  logic [PACK_RATIO-1:0]                 m_keep_q, m_keep_d, keep_now;
  logic                                  m_valid_q, m_valid_d;
  logic                                  out_free, move, flush_req;

  assign out_free = !m_valid_q || m_if.m_ready;
  assign move     = out_free && ((acc_count_q == FULL) || flush_req);

`ifdef PACK_TIMEOUT_EN
  logic idle, flush_move;
  assign idle       = (acc_count_q != '0) && (acc_count_q != FULL) && !rd_pend_q && !rinc;
  assign flush_move = flush_req && out_free;

  pack_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk       (rclk),
    .rst       (rrst),
    .idle      (idle),
    .clear     (rinc || rd_pend_q || flush_move),
    .flush_req (flush_req)
  );
`else
  assign flush_req = 1'b0;
`endif

  // Pop only if the landing byte is guaranteed a free lane after this cycle's move.
  always_comb begin
    base_count = move ? '0 : acc_count_q;
    rinc       = !rrst && !rempty && !flush_req &&
                 ((32'(base_count) + 32'(rd_pend_q)) < 32'(PACK_RATIO));
    for (int i = 0; i < PACK_RATIO; i++) keep_now[i] = (acc_count_q > CW'(i));
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    acc_d       = acc_q;
    acc_count_d = base_count;
    rd_pend_d   = rinc;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_valid_d   = m_valid_q;

    if (move) begin
      m_valid_d = 1'b1;
      m_keep_d  = keep_now;
      for (int i = 0; i < PACK_RATIO; i++)
        m_data_d[i*DATA_LINES +: DATA_LINES] = keep_now[i] ? acc_q[i] : '0;
    end else if (m_valid_q && m_if.m_ready) begin
      m_valid_d = 1'b0;
    end

    if (rd_pend_q) begin
      acc_d[IW'(base_count)] = rdata;
      acc_count_d            = base_count + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc_count_q <= '0;
      rd_pend_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      acc_count_q <= acc_count_d;
      rd_pend_q   <= rd_pend_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_valid_q   <= m_valid_d;
    end
  end

  // NOTE: lane storage is not reset; acc_count gates every read of it, so stale bytes never escape.
  always_ff @(posedge rclk) begin
    acc_q <= acc_d;
  end

  assign m_if.m_data  = m_data_q;
  assign m_if.m_keep  = m_keep_q;
  assign m_if.m_valid = m_valid_q;

endmodule
